// File: rtl/beep_pkg.sv
// Shared encodings, note frequencies, melody tables and sequencer state for beep_sfx_gen.
package beep_pkg;

    localparam logic [1:0] MODE_START = 2'b00;
    localparam logic [1:0] MODE_PLAY  = 2'b01;
    localparam logic [1:0] MODE_PAUSE = 2'b10;
    localparam logic [1:0] MODE_OVER  = 2'b11;

    localparam int unsigned C4_HZ = 262;
    localparam int unsigned E4_HZ = 330;
    localparam int unsigned G4_HZ = 392;
    localparam int unsigned C5_HZ = 523;
    localparam int unsigned E5_HZ = 659;
    localparam int unsigned G5_HZ = 784;
    localparam int unsigned C6_HZ = 1047;
    localparam int unsigned FB_HZ = 2000;

    localparam logic [1:0] START_LAST = 2'd3;
    localparam logic [1:0] OVER_LAST  = 2'd2;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_PLAY,
        SEQ_DONE
    } seq_state_t;

    function automatic int unsigned start_note_hz(input logic [1:0] idx);
        case (idx)
            2'd0:    return C5_HZ;
            2'd1:    return E5_HZ;
            2'd2:    return G5_HZ;
            default: return C6_HZ;
        endcase
    endfunction

    function automatic int unsigned over_note_hz(input logic [1:0] idx);
        case (idx)
            2'd0:    return G4_HZ;
            2'd1:    return E4_HZ;
            default: return C4_HZ;
        endcase
    endfunction

    function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned hz);
        return clk_hz / (2 * hz);
    endfunction

endpackage

// File: rtl/beep_sfx_gen_if.sv
// Game-side bus of the sound generator: mode and jump switch in, buzzer drive out.
interface beep_sfx_gen_if;
    logic [1:0] gamemode;
    logic       sw;
    logic       beep;

    modport master (output gamemode, output sw, input beep);
    modport slave  (input gamemode, input sw, output beep);
endinterface

// File: rtl/beep_tone_gen.sv
// Square-wave tone generator: toggles beep every 'half' cycles; restart or disable clears phase low.
module beep_tone_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        restart,
    input  logic [31:0] half,
    output logic        beep
);

    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en || restart) begin
            cnt  <= 32'd0;
            beep <= 1'b0;
        end else if (cnt == half - 32'd1) begin
            cnt  <= 32'd0;
            beep <= ~beep;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/beep_sfx_gen.sv
// Game sound-effect generator: start jingle, jump beeps, game-over melody on one buzzer pin.
// Optional build macro BEEP_START_LOOP_EN repeats the start jingle after a silent gap.
//   state    | meaning
//   SEQ_IDLE | no sound; in play mode waiting for a jump-switch edge
//   SEQ_PLAY | a note or feedback beep is sounding, dur_q counts down its length
//   SEQ_DONE | melody finished, beep held low (gap countdown when looping)
module beep_sfx_gen
    import beep_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned NOTE_MS_START = 150,
    parameter int unsigned NOTE_MS_OVER  = 250,
    parameter int unsigned FB_MS         = 60,
    parameter int unsigned LOOP_GAP_MS   = 1000
) (
    input logic            clk,
    input logic            rst,
    beep_sfx_gen_if.slave  bus
);

    localparam logic [31:0] DS_LOAD = (CLK_HZ / 1000) * NOTE_MS_START - 1;
    localparam logic [31:0] DO_LOAD = (CLK_HZ / 1000) * NOTE_MS_OVER - 1;
    localparam logic [31:0] DF_LOAD = (CLK_HZ / 1000) * FB_MS - 1;
    localparam logic [31:0] DG_LOAD = (CLK_HZ / 1000) * LOOP_GAP_MS - 1;

    localparam logic [31:0] H_S0 = half_period(CLK_HZ, start_note_hz(2'd0));
    localparam logic [31:0] H_S1 = half_period(CLK_HZ, start_note_hz(2'd1));
    localparam logic [31:0] H_S2 = half_period(CLK_HZ, start_note_hz(2'd2));
    localparam logic [31:0] H_S3 = half_period(CLK_HZ, start_note_hz(2'd3));
    localparam logic [31:0] H_O0 = half_period(CLK_HZ, over_note_hz(2'd0));
    localparam logic [31:0] H_O1 = half_period(CLK_HZ, over_note_hz(2'd1));
    localparam logic [31:0] H_O2 = half_period(CLK_HZ, over_note_hz(2'd2));
    localparam logic [31:0] H_FB = half_period(CLK_HZ, FB_HZ);

    seq_state_t  state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] dur_q, dur_d;
    logic [1:0]  mode_q;
    logic        started_q;
    logic        sw_s1, sw_s2, sw_s3;

    logic [1:0]  gm;
    logic        entry, sw_edge;
    logic [1:0]  last_idx;
    logic [31:0] note_load;
    logic        tone_en, restart;
    logic [31:0] tone_half;
    logic        tone_beep;

    assign gm        = bus.gamemode;
    assign entry     = !started_q || (gm != mode_q);
    assign sw_edge   = sw_s2 ^ sw_s3;
    assign last_idx  = (gm == MODE_START) ? START_LAST : OVER_LAST;
    assign note_load = (gm == MODE_START) ? DS_LOAD : DO_LOAD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEQ_IDLE;
            idx_q     <= 2'd0;
            dur_q     <= 32'd0;
            mode_q    <= MODE_START;
            started_q <= 1'b0;
            sw_s1     <= 1'b0;
            sw_s2     <= 1'b0;
            sw_s3     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dur_q     <= dur_d;
            mode_q    <= gm;
            started_q <= 1'b1;
            sw_s1     <= bus.sw;
            sw_s2     <= sw_s1;
            sw_s3     <= sw_s2;
        end
    end

    // A mode entry wins over everything, including a coincident switch edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        restart = 1'b0;
        if (entry) begin
            restart = 1'b1;
            idx_d   = 2'd0;
            dur_d   = 32'd0;
            state_d = SEQ_IDLE;
            if (gm == MODE_START) begin
                state_d = SEQ_PLAY;
                dur_d   = DS_LOAD;
            end else if (gm == MODE_OVER) begin
                state_d = SEQ_PLAY;
                dur_d   = DO_LOAD;
            end
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (gm == MODE_PLAY && sw_edge) begin
                        state_d = SEQ_PLAY;
                        dur_d   = DF_LOAD;
                        restart = 1'b1;
                    end
                end
                SEQ_PLAY: begin
                    if (gm == MODE_PLAY) begin
                        if (sw_edge) begin
                            dur_d   = DF_LOAD;
                            restart = 1'b1;
                        end else if (dur_q == 32'd0) begin
                            state_d = SEQ_IDLE;
                        end else begin
                            dur_d = dur_q - 32'd1;
                        end
                    end else if (dur_q != 32'd0) begin
                        dur_d = dur_q - 32'd1;
                    end else if (idx_q == last_idx) begin
                        state_d = SEQ_DONE;
                        dur_d   = DG_LOAD;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        dur_d   = note_load;
                        restart = 1'b1;
                    end
                end
                SEQ_DONE: begin
`ifdef BEEP_START_LOOP_EN
                    if (gm == MODE_START) begin
                        if (dur_q != 32'd0) begin
                            dur_d = dur_q - 32'd1;
                        end else begin
                            state_d = SEQ_PLAY;
                            idx_d   = 2'd0;
                            dur_d   = DS_LOAD;
                            restart = 1'b1;
                        end
                    end
`endif
                end
                default: state_d = SEQ_IDLE;
            endcase
        end

        tone_en   = (state_d == SEQ_PLAY);
        tone_half = H_FB;
        if (gm == MODE_START) begin
            case (idx_d)
                2'd0:    tone_half = H_S0;
                2'd1:    tone_half = H_S1;
                2'd2:    tone_half = H_S2;
                default: tone_half = H_S3;
            endcase
        end else if (gm == MODE_OVER) begin
            case (idx_d)
                2'd0:    tone_half = H_O0;
                2'd1:    tone_half = H_O1;
                default: tone_half = H_O2;
            endcase
        end
    end

    beep_tone_gen u_tone (
        .clk     (clk),
        .rst     (rst),
        .en      (tone_en),
        .restart (restart),
        .half    (tone_half),
        .beep    (tone_beep)
    );

    assign bus.beep = tone_beep;

endmodule

// File: tb/tb_beep_sfx_gen.sv
// Bench for beep_sfx_gen: randomized mode/switch/reset stimulus against a waveform model.
module tb_beep_sfx_gen;

    localparam int unsigned CLK_HZ = 10_000;
    localparam longint DS = (CLK_HZ / 1000) * 150;
    localparam longint DO = (CLK_HZ / 1000) * 250;
    localparam longint DF = (CLK_HZ / 1000) * 60;
    localparam longint DG = (CLK_HZ / 1000) * 1000;
    localparam int F_START [4] = '{523, 659, 784, 1047};
    localparam int F_OVER  [3] = '{392, 330, 262};
    localparam int F_FB        = 2000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    beep_sfx_gen_if bus ();

    beep_sfx_gen #(.CLK_HZ(CLK_HZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    string       phase  = "reset";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model: each sound is a function of edges elapsed since it was triggered.
    longint     cyc = 0;
    longint     entry_n = 0;
    longint     trig_n = 0;
    bit         trig_v = 1'b0;
    bit         started = 1'b0;
    logic [1:0] prev_gm = 2'b00;
    bit         sw_q [$] = '{1'b0, 1'b0, 1'b0, 1'b0};
    bit         exp_beep = 1'b0;
    bit         model_live = 1'b0;

    function automatic bit square(input longint k, input longint h);
        return ((k / h) % 2) == 1;
    endfunction

    function automatic bit expected(input logic [1:0] gm, input longint n);
        longint k;
        case (gm)
            2'b00: begin
                k = n - entry_n;
`ifdef BEEP_START_LOOP_EN
                k = k % (4 * DS + DG);
`endif
                if (k < 4 * DS) return square(k % DS, CLK_HZ / (2 * F_START[int'(k / DS)]));
                return 1'b0;
            end
            2'b11: begin
                k = n - entry_n;
                if (k < 3 * DO) return square(k % DO, CLK_HZ / (2 * F_OVER[int'(k / DO)]));
                return 1'b0;
            end
            2'b01: begin
                if (trig_v && (n - trig_n) < DF) return square(n - trig_n, CLK_HZ / (2 * F_FB));
                return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc++;
        model_live = 1'b1;
        if (rst) begin
            started  = 1'b0;
            trig_v   = 1'b0;
            sw_q     = '{1'b0, 1'b0, 1'b0, 1'b0};
            exp_beep = 1'b0;
        end else begin
            bit sw_edge;
            sw_q.push_back(bus.sw);
            void'(sw_q.pop_front());
            // switch value two and three samples back: two-flop latency plus edge detect
            sw_edge = (sw_q[1] != sw_q[0]);
            if (!started || bus.gamemode != prev_gm) begin
                entry_n = cyc;
                trig_v  = 1'b0;
            end else if (bus.gamemode == 2'b01 && sw_edge) begin
                trig_v = 1'b1;
                trig_n = cyc;
            end
            started  = 1'b1;
            prev_gm  = bus.gamemode;
            exp_beep = expected(bus.gamemode, cyc);
        end
    end

    always @(negedge clk) begin
        if (model_live) check(phase, {31'b0, bus.beep}, {31'b0, exp_beep});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic time_to_rise(input string tag, input int exp_cycles);
        int cnt = 0;
        while (cnt < 400 && bus.beep !== 1'b1) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check(tag, cnt, exp_cycles);
    endtask

    initial begin
        rst          = 1'b1;
        bus.gamemode = 2'b00;
        bus.sw       = 1'b0;
        step(3);
        rst   = 1'b0;
        phase = "jingle";
        // entry edge is the first edge after release; rise H edges later
        time_to_rise("first_rise_c5", CLK_HZ / (2 * 523) + 1);
`ifdef BEEP_START_LOOP_EN
        step(int'(8 * DS + DG + 500) - (CLK_HZ / (2 * 523) + 1));
`else
        step(int'(4 * DS + 2000) - (CLK_HZ / (2 * 523) + 1));
`endif

        bus.gamemode = 2'b10;
        step(5);
        bus.gamemode = 2'b00;
        phase = "jingle_reentry";
        step(int'(2 * DS + 100));
        bus.gamemode = 2'b11;
        phase = "over";
        step(int'(3 * DO + 1000));

        bus.gamemode = 2'b01;
        phase = "play";
        step(10);
        bus.sw = 1'b1;
        time_to_rise("fb_first_rise", 3 + CLK_HZ / (2 * F_FB));
        step(int'(DF / 2));
        bus.sw = 1'b0;
        step(int'(DF + 100));
        phase = "play_rand";
        repeat (20) begin
            bus.sw = ~bus.sw;
            step($urandom_range(1, int'(DF)));
        end
        step(int'(DF + 10));

        bus.gamemode = 2'b10;
        phase = "pause";
        repeat (20) begin
            bus.sw = ~bus.sw;
            step($urandom_range(1, 100));
        end
        step(10);
        bus.gamemode = 2'b01;
        phase = "resume";
        step(500);

        bus.gamemode = 2'b00;
        phase = "reset_mid";
        step(int'(DS + 200));
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        time_to_rise("restart_rise_c5", CLK_HZ / (2 * 523) + 1);
        step(int'(2 * DS));

        phase = "random";
        repeat (25) begin
            bus.gamemode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                step($urandom_range(1, 3));
                rst = 1'b0;
            end
            repeat ($urandom_range(0, 4)) begin
                bus.sw = ~bus.sw;
                step($urandom_range(1, 300));
            end
            step($urandom_range(1, 1200));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
